operand_arbiter: RTL and testbench

OPERAND_ARBITER -- requirements
Module: operand_arbiter

---
 rtl/operand_arbiter.sv | 90 +++++++++
 tb/tb_operand_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/operand_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output slot.
// A word is captured whenever the slot is empty or being drained in the same cycle.
module operand_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] in0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] in1,
    output logic          ack1,
    output logic          sel,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_src,
    input  logic          o_ready,
    output logic [7:0]    xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          src_q, src_d;
    logic          last_gnt_q, last_gnt_d;
    logic [7:0]    cnt_q, cnt_d;

    logic any_req;
    logic winner;
    logic slot_free;
    logic capture;
    logic deliver;

    always_comb begin
        any_req   = req0 | req1;
        // Ties go to whichever requester did not win last time.
        winner    = (req0 & req1) ? ~last_gnt_q : req1;
        slot_free = (state_q == EMPTY) | o_ready;
        capture   = rst_n & slot_free & any_req;
        deliver   = (state_q == FULL) & o_ready;

        ack0 = capture & ~winner;
        ack1 = capture & winner;
        sel  = rst_n & any_req & winner;

        state_d    = state_q;
        data_d     = data_q;
        src_d      = src_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;

        if (deliver) begin
            state_d = EMPTY;
            cnt_d   = cnt_q + 8'd1;
        end
        if (capture) begin
            state_d    = FULL;
            data_d     = winner ? in1 : in0;
            src_d      = winner;
            last_gnt_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            src_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            src_q      <= src_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_valid  = (state_q == FULL);
    assign o_data   = data_q;
    assign o_src    = src_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_operand_arbiter.sv
// Self-checking bench for operand_arbiter: directed vector table, corner sequences
// and a randomized run against a queue-based model of the output slot.
module tb_operand_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, o_ready = 1'b0;
    logic [DW-1:0] in0 = '0, in1 = '0;
    logic          ack0, ack1, sel, o_valid, o_src;
    logic [DW-1:0] o_data;
    logic [7:0]    xfer_cnt;

    operand_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .in0(in0), .ack0(ack0),
        .req1(req1), .in1(in1), .ack1(ack1),
        .sel(sel), .o_valid(o_valid), .o_data(o_data), .o_src(o_src),
        .o_ready(o_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the slot is a queue of at most one {src,data} word.
    logic [DW:0]   slot[$];
    logic [DW-1:0] m_data;
    logic          m_src;
    logic          m_last;
    int            m_cnt;
    logic          obs_a0, obs_a1, obs_sel;
    logic          exp_a0, exp_a1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot.delete();
        m_data = '0;
        m_src  = 1'b0;
        m_last = 1'b1;
        m_cnt  = 0;
    endtask

    // Entered and left on a falling edge.
    task automatic cycle(input logic r0, input logic r1, input logic [DW-1:0] i0,
                         input logic [DW-1:0] i1, input logic rdy);
        logic free, any, win, e_sel;
        req0 = r0; req1 = r1; in0 = i0; in1 = i1; o_ready = rdy;
        #1;
        any   = r0 | r1;
        free  = (slot.size() == 0) || rdy;
        win   = (r0 && r1) ? !m_last : r1;
        exp_a0 = free && any && !win;
        exp_a1 = free && any && win;
        e_sel  = any ? win : 1'b0;
        obs_a0 = ack0; obs_a1 = ack1; obs_sel = sel;
        chk("ack0", ack0, exp_a0);
        chk("ack1", ack1, exp_a1);
        chk("sel", sel, e_sel);
        @(posedge clk);
        if (slot.size() != 0 && rdy) begin
            void'(slot.pop_front());
            m_cnt = (m_cnt + 1) % 256;
        end
        if (free && any) begin
            m_data = win ? i1 : i0;
            m_src  = win;
            m_last = win;
            slot.push_back({win, m_data});
        end
        @(negedge clk);
        chk("o_valid", o_valid, slot.size() != 0);
        chk("o_data", o_data, m_data);
        chk("o_src", o_src, m_src);
        chk("xfer_cnt", xfer_cnt, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 0; req1 = 0; o_ready = 0;
        #1;
        model_reset();
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_data", o_data, '0);
        chk("rst_xfer_cnt", xfer_cnt, 8'd0);
        chk("rst_ack0", ack0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic r0, r1; logic [DW-1:0] i0, i1; logic rdy;
        logic e_a0, e_a1, e_sel, e_v; logic [DW-1:0] e_d; logic e_s;
    } vec_t;
    vec_t vecs[8];

    initial begin
        logic [DW-1:0] held;
        logic p0, p1;
        logic [DW-1:0] d0, d1;

        //          r0 r1 in0    in1    rdy a0 a1 sel v  data   src
        vecs[0] = '{1, 0, 'hAA,  'h0,   1,  1, 0, 0,  1, 'hAA,  0};
        vecs[1] = '{1, 1, 'h11,  'h22,  1,  0, 1, 1,  1, 'h22,  1};
        vecs[2] = '{1, 1, 'h11,  'h22,  1,  1, 0, 0,  1, 'h11,  0};
        vecs[3] = '{1, 1, 'h11,  'h22,  1,  0, 1, 1,  1, 'h22,  1};
        vecs[4] = '{0, 1, 'h0,   'h33,  0,  0, 0, 1,  1, 'h22,  1};
        vecs[5] = '{0, 0, 'h0,   'h0,   1,  0, 0, 0,  0, 'h22,  1};
        vecs[6] = '{0, 0, 'h0,   'h0,   1,  0, 0, 0,  0, 'h22,  1};
        vecs[7] = '{0, 1, 'h0,   'h44,  0,  0, 1, 1,  1, 'h44,  1};

        do_reset();
        foreach (vecs[i]) begin
            cycle(vecs[i].r0, vecs[i].r1, vecs[i].i0, vecs[i].i1, vecs[i].rdy);
            chk($sformatf("vec%0d_ack0", i), obs_a0, vecs[i].e_a0);
            chk($sformatf("vec%0d_ack1", i), obs_a1, vecs[i].e_a1);
            chk($sformatf("vec%0d_sel", i), obs_sel, vecs[i].e_sel);
            chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].e_v);
            chk($sformatf("vec%0d_data", i), o_data, vecs[i].e_d);
            chk($sformatf("vec%0d_src", i), o_src, vecs[i].e_s);
        end
        chk("vec_xfer_cnt", xfer_cnt, 8'd4);

        // Stalled consumer blocks a pending requester.
        do_reset();
        cycle(1, 0, 'h55, 'h0, 0);
        held = o_data;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 'h0, 'h66, 0);
            chk("stall_ack1", obs_a1, 1'b0);
            chk("stall_data", o_data, held);
        end
        cycle(0, 1, 'h0, 'h66, 1);
        chk("release_ack1", obs_a1, 1'b1);
        chk("release_data", o_data, 'h66);

        // Counter wrap after 300 deliveries.
        do_reset();
        for (int k = 0; k < 300; k++) cycle(1, 0, k, 'h0, 1);
        cycle(0, 0, 'h0, 'h0, 1);
        chk("wrap_xfer_cnt", xfer_cnt, 8'd44);
        chk("wrap_o_valid", o_valid, 1'b0);

        // Asynchronous reset while FULL and stalled.
        cycle(0, 1, 'h0, 'h77, 0);
        cycle(1, 1, 'h88, 'h99, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_o_valid", o_valid, 1'b0);
        chk("async_o_data", o_data, '0);
        chk("async_ack0", ack0, 1'b0);
        chk("async_ack1", ack1, 1'b0);
        chk("async_sel", sel, 1'b0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cycle(1, 1, 'h88, 'h99, 0);
        chk("post_rst_tie_ack0", obs_a0, 1'b1);
        chk("post_rst_tie_data", o_data, 'h88);

        // Randomized traffic; requesters hold their word until acknowledged.
        do_reset();
        p0 = 0; p1 = 0; d0 = '0; d1 = '0;
        for (int k = 0; k < 600; k++) begin
            if (!p0 && ($urandom_range(0, 3) != 0)) begin p0 = 1; d0 = $urandom; end
            if (!p1 && ($urandom_range(0, 3) != 0)) begin p1 = 1; d1 = $urandom; end
            cycle(p0, p1, d0, d1, $urandom_range(0, 2) != 0);
            if (exp_a0) p0 = 0;
            if (exp_a1) p1 = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
